// File: rtl/stream_video_pkg.sv
// rtl/stream_video_pkg.sv - shared constants, state encoding and LFSR helper for the video TPG
package stream_video_pkg;

    localparam logic [2:0] PAT_SOLID   = 3'd0;
    localparam logic [2:0] PAT_RAMP    = 3'd1;
    localparam logic [2:0] PAT_BARS    = 3'd2;
    localparam logic [2:0] PAT_CHECKER = 3'd3;
    localparam logic [2:0] PAT_NOISE   = 3'd4;

    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_LINE_GAP  = 2'd2,
        ST_FRAME_GAP = 2'd3
    } tpg_state_t;

    // x^24+x^23+x^22+x^17+1 -> state bits 23,22,21,16
    localparam logic [23:0] LFSR_SEED = 24'h000001;
    localparam logic [23:0] LFSR_TAPS = 24'hE10000;

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return {s[22:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return COLOR_WHITE;
            3'd1:    return COLOR_YELLOW;
            3'd2:    return COLOR_CYAN;
            3'd3:    return COLOR_GREEN;
            3'd4:    return COLOR_MAGENTA;
            3'd5:    return COLOR_RED;
            3'd6:    return COLOR_BLUE;
            default: return COLOR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/stream_video_lfsr.sv
// rtl/stream_video_lfsr.sv - 24-bit Fibonacci LFSR for the noise pattern
module stream_video_lfsr
    import stream_video_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [23:0] state
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/stream_video_tpg.sv
// rtl/stream_video_tpg.sv - AXI4-Stream video test-pattern generator (noise pattern under STREAM_VIDEO_TPG_NOISE_EN)
module stream_video_tpg
    import stream_video_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 8,
    parameter int LINE_GAP   = 0,
    parameter int FRAME_GAP  = 4,
    parameter int CHK_SHIFT  = 2,
    parameter int CNT_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int GAP_W = 16;
    localparam int BAR_W = (IMG_WIDTH / 8 < 1) ? 1 : IMG_WIDTH / 8;
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    tpg_state_t state, next_state;

    logic [CNT_W-1:0] x, y, nx, ny;
    logic [CNT_W-1:0] bar_pix, bar_pix_n;
    logic [2:0]       bar_idx, bar_idx_n;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       pat_q, pat_n;
    logic [23:0]      color_q, color_n;
    logic [23:0]      pixel, noise_pixel;
    logic             xfer, line_end, frame_end, gap_done;
    logic             load_pixel, start_frame;

    assign xfer      = m_axis_video_tvalid && m_axis_video_tready;
    assign line_end  = xfer && (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);
    assign gap_done  = (gap_cnt == GAP_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (frame_end) begin
                    if (FRAME_GAP != 0)  next_state = ST_FRAME_GAP;
                    else if (!enable)    next_state = ST_IDLE;
                end else if (line_end && LINE_GAP != 0) begin
                    next_state = ST_LINE_GAP;
                end
            end
            ST_LINE_GAP: begin
                if (gap_done) next_state = ST_ACTIVE;
            end
            ST_FRAME_GAP: begin
                if (gap_done) next_state = enable ? ST_ACTIVE : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Next-pixel computation: the output registers always hold the pixel at (x, y).
    always_comb begin
        start_frame = 1'b0;
        load_pixel  = 1'b0;
        nx          = x;
        ny          = y;
        pat_n       = pat_q;
        color_n     = color_q;
        bar_idx_n   = bar_idx;
        bar_pix_n   = bar_pix;
        pixel       = COLOR_BLACK;

        if (next_state == ST_ACTIVE) begin
            load_pixel  = (state != ST_ACTIVE) || xfer;
            start_frame = (state == ST_IDLE) || (state == ST_FRAME_GAP) || frame_end;
        end

        if (start_frame) begin
            nx      = '0;
            ny      = '0;
            pat_n   = pattern_sel;
            color_n = solid_color;
        end else if (xfer) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                nx = x + 1'b1;
            end
        end

        // Bar index tracks pixels within the current bar instead of dividing x.
        if (nx == '0) begin
            bar_idx_n = 3'd0;
            bar_pix_n = '0;
        end else if (bar_pix == BAR_LAST) begin
            bar_pix_n = '0;
            bar_idx_n = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
        end else begin
            bar_pix_n = bar_pix + 1'b1;
        end

        case (pat_n)
            PAT_SOLID:   pixel = color_n;
            PAT_RAMP:    pixel = {nx[7:0], nx[7:0], nx[7:0]};
            PAT_BARS:    pixel = bar_color(bar_idx_n);
            PAT_CHECKER: pixel = (nx[CHK_SHIFT] ^ ny[CHK_SHIFT]) ? COLOR_WHITE : COLOR_BLACK;
            PAT_NOISE:   pixel = noise_pixel;
            default:     pixel = color_n;
        endcase
    end

`ifdef STREAM_VIDEO_TPG_NOISE_EN
    logic        noise_adv;
    logic [23:0] noise_state;

    assign noise_adv = xfer && (pat_q == PAT_NOISE);

    stream_video_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (noise_adv),
        .state   (noise_state)
    );

    // The pixel following a noise transfer must already show the advanced state.
    assign noise_pixel = noise_adv ? lfsr_step(noise_state) : noise_state;
`else
    assign noise_pixel = color_n;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            x                   <= '0;
            y                   <= '0;
            bar_idx             <= 3'd0;
            bar_pix             <= '0;
            gap_cnt             <= '0;
            pat_q               <= PAT_SOLID;
            color_q             <= '0;
            frame_cnt           <= '0;
            busy                <= 1'b0;
            m_axis_video_tdata  <= '0;
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tuser  <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
        end else begin
            x    <= nx;
            y    <= ny;
            busy <= (next_state != ST_IDLE);
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
            if (start_frame) begin
                pat_q   <= pat_n;
                color_q <= color_n;
            end

            if (state == ST_ACTIVE && next_state == ST_LINE_GAP) begin
                gap_cnt <= GAP_W'(LINE_GAP);
            end else if (state == ST_ACTIVE && next_state == ST_FRAME_GAP) begin
                gap_cnt <= GAP_W'(FRAME_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (load_pixel) begin
                m_axis_video_tvalid <= 1'b1;
                m_axis_video_tdata  <= pixel;
                m_axis_video_tuser  <= start_frame;
                m_axis_video_tlast  <= (nx == X_LAST);
                bar_idx             <= bar_idx_n;
                bar_pix             <= bar_pix_n;
            end else if (xfer) begin
                m_axis_video_tvalid <= 1'b0;
                m_axis_video_tuser  <= 1'b0;
                m_axis_video_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_video_tpg.sv
// tb/tb_stream_video_tpg.sv - directed self-checking bench for stream_video_tpg
module tb_stream_video_tpg;

    logic        clk = 1'b0;
    logic        reset, tready, en_a, en_b;
    logic [2:0]  pat;
    logic [23:0] solid;

    logic [23:0] a_tdata, b_tdata;
    logic        a_tvalid, a_tuser, a_tlast, a_busy;
    logic        b_tvalid, b_tuser, b_tlast, b_busy;
    logic [15:0] a_fcnt, b_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] bd [200];
    logic        bu [200];
    logic        bl [200];
    int          bc [200];
    logic [15:0] bf [200];
    int          stall_err;

    logic [23:0] bar_exp [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    stream_video_tpg #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .LINE_GAP(0), .FRAME_GAP(0),
                       .CHK_SHIFT(2), .CNT_W(12)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .pattern_sel(pat), .solid_color(solid),
        .m_axis_video_tdata(a_tdata), .m_axis_video_tvalid(a_tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(a_tuser),
        .m_axis_video_tlast(a_tlast), .frame_cnt(a_fcnt), .busy(a_busy)
    );

    stream_video_tpg #(.IMG_WIDTH(16), .IMG_HEIGHT(2), .LINE_GAP(3), .FRAME_GAP(5),
                       .CHK_SHIFT(2), .CNT_W(12)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .pattern_sel(pat), .solid_color(solid),
        .m_axis_video_tdata(b_tdata), .m_axis_video_tvalid(b_tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(b_tuser),
        .m_axis_video_tlast(b_tlast), .frame_cnt(b_fcnt), .busy(b_busy)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic collect(input bit sel_b, input int n, input bit rand_rdy,
                           input int drop_at, output int got);
        logic [23:0] held_d, d;
        logic        held_u, held_l, stalled, v, u, l;
        logic [15:0] f;
        got = 0; stalled = 1'b0; stall_err = 0;
        held_d = '0; held_u = 1'b0; held_l = 1'b0;
        for (int c = 0; c < 600 && got < n; c++) begin
            v = sel_b ? b_tvalid : a_tvalid;
            d = sel_b ? b_tdata  : a_tdata;
            u = sel_b ? b_tuser  : a_tuser;
            l = sel_b ? b_tlast  : a_tlast;
            f = sel_b ? b_fcnt   : a_fcnt;
            if (stalled && (!v || d !== held_d || u !== held_u || l !== held_l)) stall_err++;
            tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v && tready) begin
                bd[got] = d; bu[got] = u; bl[got] = l; bc[got] = c; bf[got] = f;
                if (got == drop_at) begin
                    en_a = 1'b0; en_b = 1'b0; pat = 3'd3;
                end
                got++;
                stalled = 1'b0;
            end else if (v) begin
                stalled = 1'b1; held_d = d; held_u = u; held_l = l;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; tready = 1'b1; pat = 3'd0; solid = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_tvalid, a_tuser, a_tlast, a_busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_a_flags: got %b expected 0000", {a_tvalid, a_tuser, a_tlast, a_busy});
        end
        n_checks++;
        if (a_tdata !== 24'h0 || a_fcnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_a_data: got %h/%h expected 0/0", a_tdata, a_fcnt);
        end
        n_checks++;
        if ({b_tvalid, b_tuser, b_tlast, b_busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_b_flags: got %b expected 0000", {b_tvalid, b_tuser, b_tlast, b_busy});
        end
        n_checks++;
        if (b_tdata !== 24'h0 || b_fcnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_b_data: got %h/%h expected 0/0", b_tdata, b_fcnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_frame(input bit rand_rdy);
        int got;
        do_reset();
        pat = 3'd1; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        collect(1'b0, 8, rand_rdy, -1, got);
        n_checks++;
        if (got !== 8) begin n_fail++; $display("FAIL basic_beats: got %0d expected 8", got); end
        for (int i = 0; i < got; i++) begin
            logic [7:0] xv;
            xv = 8'(i % 4);
            n_checks++;
            if (bd[i] !== {xv, xv, xv} || bu[i] !== (i == 0) || bl[i] !== (i % 4 == 3)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h u%b l%b expected %h u%b l%b",
                         i, bd[i], bu[i], bl[i], {xv, xv, xv}, i == 0, i % 4 == 3);
            end
            if (!rand_rdy) begin
                n_checks++;
                if (bc[i] - bc[0] !== i) begin
                    n_fail++; $display("FAIL basic_rate%0d: got cycle %0d expected %0d", i, bc[i] - bc[0], i);
                end
            end
        end
        n_checks++;
        if (stall_err !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stall_err); end
        tready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (a_fcnt !== 16'd1 || a_busy !== 1'b0 || a_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL basic_end: got fcnt %0d busy %b valid %b expected 1 0 0", a_fcnt, a_busy, a_tvalid);
        end
    endtask

    task automatic test_bars();
        int got;
        do_reset();
        pat = 3'd2; en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        collect(1'b1, 32, 1'b0, -1, got);
        n_checks++;
        if (got !== 32) begin n_fail++; $display("FAIL bars_beats: got %0d expected 32", got); end
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (bd[i] !== bar_exp[(i % 16) / 2] || bl[i] !== (i % 16 == 15)) begin
                n_fail++; $display("FAIL bars_px%0d: got %h l%b expected %h l%b", i, bd[i], bl[i], bar_exp[(i % 16) / 2], i % 16 == 15);
            end
        end
    endtask

    task automatic test_checker_and_solid();
        int got;
        do_reset();
        pat = 3'd3; en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        collect(1'b1, 16, 1'b0, -1, got);
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (bd[i] !== (((i >> 2) & 1) != 0 ? 24'hFFFFFF : 24'h000000)) begin
                n_fail++; $display("FAIL checker_px%0d: got %h", i, bd[i]);
            end
        end
        do_reset();
        pat = 3'd5; solid = 24'hA5C3E1; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0; pat = 3'd1; solid = 24'h000000;
        collect(1'b0, 8, 1'b0, -1, got);
        n_checks++;
        if (got !== 8) begin n_fail++; $display("FAIL solid_beats: got %0d expected 8", got); end
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (bd[i] !== 24'hA5C3E1) begin n_fail++; $display("FAIL solid_px%0d: got %h expected a5c3e1", i, bd[i]); end
        end
    endtask

    task automatic test_gaps();
        int got, exp_d;
        do_reset();
        pat = 3'd1; en_b = 1'b1;
        @(negedge clk);
        collect(1'b1, 96, 1'b0, 95, got);
        n_checks++;
        if (got !== 96) begin n_fail++; $display("FAIL gaps_beats: got %0d expected 96", got); end
        for (int i = 1; i < got; i++) begin
            logic [7:0] xv;
            xv = 8'(i % 16);
            exp_d = (i % 32 == 0) ? 6 : (i % 16 == 0) ? 4 : 1;
            n_checks++;
            if (bc[i] - bc[i-1] !== exp_d || bd[i] !== {xv, xv, xv} || bu[i] !== (i % 32 == 0)) begin
                n_fail++; $display("FAIL gaps_beat%0d: got dist %0d data %h u%b expected %0d %h %b",
                                   i, bc[i] - bc[i-1], bd[i], bu[i], exp_d, {xv, xv, xv}, i % 32 == 0);
            end
        end
        n_checks++;
        if (bf[32] !== 16'd1 || bf[64] !== 16'd2) begin
            n_fail++; $display("FAIL gaps_fcnt: got %0d,%0d expected 1,2", bf[32], bf[64]);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (b_fcnt !== 16'd3 || b_busy !== 1'b0 || b_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL gaps_end: got fcnt %0d busy %b valid %b expected 3 0 0", b_fcnt, b_busy, b_tvalid);
        end
    endtask

    task automatic test_mid_frame();
        int got, vcnt;
        do_reset();
        pat = 3'd1; en_a = 1'b1;
        @(negedge clk);
        collect(1'b0, 8, 1'b0, 5, got);
        n_checks++;
        if (got !== 8) begin n_fail++; $display("FAIL mid_beats: got %0d expected 8", got); end
        for (int i = 0; i < got; i++) begin
            logic [7:0] xv;
            xv = 8'(i % 4);
            n_checks++;
            if (bd[i] !== {xv, xv, xv}) begin n_fail++; $display("FAIL mid_px%0d: got %h expected %h", i, bd[i], {xv, xv, xv}); end
        end
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_tvalid) vcnt++;
            @(negedge clk);
        end
        n_checks++;
        if (vcnt !== 0 || a_fcnt !== 16'd1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_stop: got valid %0d fcnt %0d busy %b expected 0 1 0", vcnt, a_fcnt, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        logic [23:0] exp [3];
`ifdef STREAM_VIDEO_TPG_NOISE_EN
        exp = '{24'h000001, 24'h000002, 24'h000004};
`else
        exp = '{24'h123456, 24'h123456, 24'h123456};
`endif
        do_reset();
        pat = 3'd4; solid = 24'h123456; en_a = 1'b1;
        @(negedge clk);
        collect(1'b0, 3, 1'b0, -1, got);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bd[i] !== exp[i]) begin n_fail++; $display("FAIL pat4_px%0d: got %h expected %h", i, bd[i], exp[i]); end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_tvalid, a_tlast, a_busy} !== 3'b0 || a_fcnt !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_state: got %b fcnt %0d expected 000 0", {a_tvalid, a_tlast, a_busy}, a_fcnt);
        end
        reset = 1'b1;
        @(negedge clk);
        collect(1'b0, 1, 1'b0, -1, got);
        n_checks++;
        if (got !== 1 || bd[0] !== exp[0] || bu[0] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_restart: got %h u%b expected %h u1", bd[0], bu[0], exp[0]);
        end
        en_a = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame(1'b0);
        test_basic_frame(1'b1);
        test_bars();
        test_checker_and_solid();
        test_gaps();
        test_mid_frame();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
